// File: rtl/pong_ball.sv
// pong_ball - ball engine for the Pong playfield.
//
// Moves a square ball STEP pixels per axis on each animation tick, bounces it
// off the left/right/top walls and the top face of the player paddle, detects
// floor misses, and tracks serve delay, lives and paddle hits.
//
// Ports:
//   i_clk, i_rst          base clock, synchronous active-high reset
//   i_ani_stb             animation strobe, one i_clk cycle per frame
//   i_animate             enable; strobes are ignored while low
//   i_pad_x1/x2/y1        paddle left, right and top edges
//   o_x1/o_x2/o_y1/o_y2   ball edges (centre +/- H_SIZE), combinational
//   o_hits                paddle hits, saturating at 255
//   o_lives               remaining lives
//   o_miss                one-cycle pulse after a floor miss
//   o_game_over           high once all lives are spent
module pong_ball #(
    parameter int H_SIZE       = 8,
    parameter int IX           = 320,
    parameter int IY           = 100,
    parameter int D_WIDTH      = 640,
    parameter int D_HEIGHT     = 480,
    parameter int STEP         = 2,
    parameter int SERVE_FRAMES = 4,
    parameter int LIVES        = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic [11:0] i_pad_x1,
    input  logic [11:0] i_pad_x2,
    input  logic [11:0] i_pad_y1,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic [7:0]  o_hits,
    output logic [1:0]  o_lives,
    output logic        o_miss,
    output logic        o_game_over
);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS, S_OVER} state_t;

    localparam int CW = $clog2(SERVE_FRAMES) + 1;

    // Limits widened to 13 bits so edge + STEP never wraps.
    localparam logic [12:0] L_STEP = 13'(STEP);
    localparam logic [12:0] L_XMAX = 13'(D_WIDTH - 1);
    localparam logic [12:0] L_YMAX = 13'(D_HEIGHT - 1);

    state_t          r_state, w_state_n;
    logic [11:0]     r_x, r_y, w_x_n, w_y_n;
    logic            r_dx, r_dy, w_dx_n, w_dy_n;   // dx: 1 = right, dy: 1 = down
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [7:0]      r_hits, w_hits_n;
    logic [1:0]      r_lives, w_lives_n;
    logic            r_miss, w_miss_n;

    logic            w_tick;
    logic [12:0]     w_x1, w_x2, w_y1, w_y2;
    logic            w_hit;

    assign o_x1 = r_x - 12'(H_SIZE);
    assign o_x2 = r_x + 12'(H_SIZE);
    assign o_y1 = r_y - 12'(H_SIZE);
    assign o_y2 = r_y + 12'(H_SIZE);

    assign w_x1 = {1'b0, o_x1};
    assign w_x2 = {1'b0, o_x2};
    assign w_y1 = {1'b0, o_y1};
    assign w_y2 = {1'b0, o_y2};

    assign w_tick = i_animate & i_ani_stb;

    // Bottom edge within one step above the paddle top, horizontally overlapping.
    assign w_hit = (w_y2 <= {1'b0, i_pad_y1}) &&
                   ((w_y2 + L_STEP) >= {1'b0, i_pad_y1}) &&
                   (w_x2 >= {1'b0, i_pad_x1}) &&
                   (w_x1 <= {1'b0, i_pad_x2});

    assign o_hits      = r_hits;
    assign o_lives     = r_lives;
    assign o_miss      = r_miss;
    assign o_game_over = (r_state == S_OVER);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_SERVE;
            r_x     <= 12'(IX);
            r_y     <= 12'(IY);
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
            r_cnt   <= '0;
            r_hits  <= '0;
            r_lives <= 2'(LIVES);
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_dx    <= w_dx_n;
            r_dy    <= w_dy_n;
            r_cnt   <= w_cnt_n;
            r_hits  <= w_hits_n;
            r_lives <= w_lives_n;
            r_miss  <= w_miss_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_dx_n    = r_dx;
        w_dy_n    = r_dy;
        w_cnt_n   = r_cnt;
        w_hits_n  = r_hits;
        w_lives_n = r_lives;
        w_miss_n  = 1'b0;      // pulse clears on the next clock, tick or not

        if (w_tick) begin
            case (r_state)
                S_SERVE: begin
                    if (r_cnt == CW'(SERVE_FRAMES - 1)) begin
                        w_cnt_n   = '0;
                        w_state_n = S_PLAY;
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                    end
                end

                S_PLAY: begin
                    // x axis
                    if (!r_dx) begin
                        if (w_x1 < L_STEP) begin
                            w_x_n  = 12'(H_SIZE);
                            w_dx_n = 1'b1;
                        end else begin
                            w_x_n = r_x - 12'(STEP);
                        end
                    end else if ((w_x2 + L_STEP) > L_XMAX) begin
                        w_x_n  = 12'(D_WIDTH - 1 - H_SIZE);
                        w_dx_n = 1'b0;
                    end else begin
                        w_x_n = r_x + 12'(STEP);
                    end

                    // y axis; paddle hit takes priority over a floor miss
                    if (!r_dy) begin
                        if (w_y1 < L_STEP) begin
                            w_y_n  = 12'(H_SIZE);
                            w_dy_n = 1'b1;
                        end else begin
                            w_y_n = r_y - 12'(STEP);
                        end
                    end else if (w_hit) begin
                        w_y_n  = i_pad_y1 - 12'(H_SIZE);
                        w_dy_n = 1'b0;
                        if (r_hits != '1)
                            w_hits_n = r_hits + 8'd1;
                    end else if ((w_y2 + L_STEP) > L_YMAX) begin
                        w_y_n     = 12'(D_HEIGHT - 1 - H_SIZE);
                        w_lives_n = r_lives - 2'd1;
                        w_miss_n  = 1'b1;
                        w_state_n = S_MISS;
                    end else begin
                        w_y_n = r_y + STEP[11:0];
                    end
                end

                S_MISS: begin
                    if (r_lives == '0) begin
                        w_state_n = S_OVER;
                    end else begin
                        w_state_n = S_SERVE;
                        w_x_n     = 12'(IX);
                        w_y_n     = 12'(IY);
                        w_dy_n    = 1'b1;
                    end
                end

                S_OVER: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball - self-checking bench for pong_ball.
//
// A behavioural model of the ball (integer centre, direction flags, mode,
// counters) advances on every clock from the same inputs as the design; a
// compare process checks all outputs against it on every falling edge.
// Directed stimulus walks through serve, wall bounce, paddle hit, misses,
// game over, enable gating and reset-during-tick, with hand-computed literal
// checks at key points.
module tb_pong_ball;

    localparam int H    = 8;
    localparam int IX   = 320;
    localparam int IY   = 100;
    localparam int W    = 640;
    localparam int HT   = 480;
    localparam int STEP = 2;
    localparam int SF   = 4;
    localparam int LV   = 3;

    localparam int M_SERVE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_MISS  = 2;
    localparam int M_OVER  = 3;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ani_stb = 1'b0;
    logic        i_animate = 1'b1;
    logic [11:0] i_pad_x1 = 12'd560;
    logic [11:0] i_pad_x2 = 12'd660;
    logic [11:0] i_pad_y1 = 12'd440;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;
    logic [7:0]  o_hits;
    logic [1:0]  o_lives;
    logic        o_miss, o_game_over;

    pong_ball #(
        .H_SIZE(H), .IX(IX), .IY(IY), .D_WIDTH(W), .D_HEIGHT(HT),
        .STEP(STEP), .SERVE_FRAMES(SF), .LIVES(LV)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
        .i_pad_x1(i_pad_x1), .i_pad_x2(i_pad_x2), .i_pad_y1(i_pad_y1),
        .o_x1(o_x1), .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2),
        .o_hits(o_hits), .o_lives(o_lives), .o_miss(o_miss), .o_game_over(o_game_over)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mx, my, mcnt, mhits, mlives, mst;
    bit mright, mdown, mmiss;
    bit armed = 1'b0;

    task automatic model_step();
        int nx, ny;
        if (i_rst) begin
            mx = IX; my = IY; mright = 1; mdown = 1;
            mst = M_SERVE; mcnt = 0; mhits = 0; mlives = LV; mmiss = 0;
            armed = 1'b1;
        end else begin
            mmiss = 0;
            if (i_animate && i_ani_stb) begin
                if (mst == M_SERVE) begin
                    if (mcnt == SF - 1) begin mcnt = 0; mst = M_PLAY; end
                    else mcnt = mcnt + 1;
                end else if (mst == M_PLAY) begin
                    nx = mx; ny = my;
                    if (!mright) begin
                        if (mx - H < STEP) begin nx = H; mright = 1; end
                        else nx = mx - STEP;
                    end else begin
                        if (mx + H + STEP > W - 1) begin nx = W - 1 - H; mright = 0; end
                        else nx = mx + STEP;
                    end
                    if (!mdown) begin
                        if (my - H < STEP) begin ny = H; mdown = 1; end
                        else ny = my - STEP;
                    end else if (my + H <= int'(i_pad_y1) && my + H + STEP >= int'(i_pad_y1) &&
                                 mx + H >= int'(i_pad_x1) && mx - H <= int'(i_pad_x2)) begin
                        ny = int'(i_pad_y1) - H; mdown = 0;
                        if (mhits < 255) mhits = mhits + 1;
                    end else if (my + H + STEP > HT - 1) begin
                        ny = HT - 1 - H; mlives = mlives - 1; mmiss = 1; mst = M_MISS;
                    end else begin
                        ny = my + STEP;
                    end
                    mx = nx; my = ny;
                end else if (mst == M_MISS) begin
                    if (mlives == 0) mst = M_OVER;
                    else begin mst = M_SERVE; mx = IX; my = IY; mdown = 1; end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge i_clk);
        model_step();
    end

    initial forever begin
        @(negedge i_clk);
        if (armed) begin
            chk("x1", o_x1, mx - H);
            chk("x2", o_x2, mx + H);
            chk("y1", o_y1, my - H);
            chk("y2", o_y2, my + H);
            chk("hits", o_hits, mhits);
            chk("lives", o_lives, mlives);
            chk("miss", o_miss, mmiss);
            chk("game_over", o_game_over, mst == M_OVER);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        i_ani_stb = 1'b1;
        @(negedge i_clk);
        i_ani_stb = 1'b0;
    endtask

    bit found;

    initial begin
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // reset state
        chk("rst_x1", o_x1, 312); chk("rst_x2", o_x2, 328);
        chk("rst_y1", o_y1, 92);  chk("rst_y2", o_y2, 108);
        chk("rst_lives", o_lives, 3); chk("rst_hits", o_hits, 0);
        chk("rst_go", o_game_over, 0); chk("rst_miss", o_miss, 0);

        // serve hold: four ticks without motion, fifth moves
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("serve_x1", o_x1, 312);
            chk("serve_y1", o_y1, 92);
        end
        tick();
        chk("play1_x1", o_x1, 314);
        chk("play1_y1", o_y1, 94);

        // right wall: centre 630 -> 631 (turn) -> 629
        repeat (154) tick();
        chk("wall_x2_630", o_x2, 638);
        tick();
        chk("wall_x1_631", o_x1, 623);
        tick();
        chk("wall_x1_629", o_x1, 621);
        chk("wall_y1", o_y1, 406);

        // paddle hit on the 166th play tick: y 430 -> 432, turning up
        repeat (8) tick();
        chk("prehit_hits", o_hits, 0);
        tick();
        chk("hit_y1", o_y1, 424);
        chk("hit_x1", o_x1, 603);
        chk("hit_hits", o_hits, 1);

        // move the paddle out of reach and wait for the first floor miss
        i_pad_x1 = 12'd4000;
        i_pad_x2 = 12'd4000;
        found = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            tick();
            if (o_miss === 1'b1) found = 1;
        end
        chk("miss_seen", found, 1);
        chk("miss_y1", o_y1, 463);
        chk("miss_lives", o_lives, 2);
        @(negedge i_clk);
        chk("miss_pulse_clear", o_miss, 0);
        tick();
        chk("reserve_x1", o_x1, 312);
        chk("reserve_y1", o_y1, 92);

        // two more misses
        for (int k = 0; k < 1000 && o_lives != 2'd0; k++) tick();
        chk("lives_zero", o_lives, 0);
        chk("pre_over_go", o_game_over, 0);
        tick();
        chk("over_go", o_game_over, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("over_y1", o_y1, 463);
            chk("over_go_hold", o_game_over, 1);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst2_lives", o_lives, 3);
        chk("rst2_go", o_game_over, 0);
        chk("rst2_x1", o_x1, 312);

        // enable gating
        repeat (9) tick();
        chk("en_x1", o_x1, 322);
        chk("en_y1", o_y1, 102);
        i_animate = 1'b0;
        repeat (20) tick();
        chk("frozen_x1", o_x1, 322);
        chk("frozen_y1", o_y1, 102);
        i_animate = 1'b1;

        // reset dominates a simultaneous tick mid-play
        i_rst = 1'b1;
        i_ani_stb = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_ani_stb = 1'b0;
        chk("rsttick_x1", o_x1, 312); chk("rsttick_x2", o_x2, 328);
        chk("rsttick_y1", o_y1, 92);  chk("rsttick_y2", o_y2, 108);
        repeat (4) tick();
        chk("rsttick_serve_x1", o_x1, 312);
        tick();
        chk("rsttick_play_x1", o_x1, 314);

        @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
